// File: rtl/ex_mem_pipe_reg_if.sv
// EX->MEM pipeline bundle: EX-side handshake/payload, MEM-side head view,
// and the occupancy count the hazard unit reads.
interface ex_mem_pipe_reg_if #(
    parameter int CTRL_M_W  = 2,
    parameter int CTRL_WB_W = 2,
    parameter int DATA_W    = 32,
    parameter int REG_W     = 5
);
    logic                 valid_e;
    logic                 ready_e;
    logic                 flush;
    logic [CTRL_M_W-1:0]  MEM_E;
    logic [CTRL_WB_W-1:0] WB_E;
    logic [DATA_W-1:0]    ALUOut_E;
    logic [DATA_W-1:0]    WriteData_E;
    logic [REG_W-1:0]     WriteReg_E;

    logic                 valid_m;
    logic                 ready_m;
    logic [CTRL_M_W-1:0]  MEM_M;
    logic [CTRL_WB_W-1:0] WB_M;
    logic [DATA_W-1:0]    ALUOut_M;
    logic [DATA_W-1:0]    WriteData_M;
    logic [REG_W-1:0]     WriteReg_M;
    logic [1:0]           occupancy;

    modport slave (
        input  valid_e, flush, MEM_E, WB_E,
        input  ALUOut_E, WriteData_E, WriteReg_E,
        input  ready_m,
        output ready_e, valid_m, MEM_M, WB_M,
        output ALUOut_M, WriteData_M, WriteReg_M,
        output occupancy
    );

    modport master (
        output valid_e, flush, MEM_E, WB_E,
        output ALUOut_E, WriteData_E, WriteReg_E,
        output ready_m,
        input  ready_e, valid_m, MEM_M, WB_M,
        input  ALUOut_M, WriteData_M, WriteReg_M,
        input  occupancy
    );
endinterface

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with a 2-entry skid buffer, flush and
// bubble-gated control fields. ready_e depends only on registered state.
module ex_mem_pipe_reg #(
    parameter int CTRL_M_W  = 2,
    parameter int CTRL_WB_W = 2,
    parameter int DATA_W    = 32,
    parameter int REG_W     = 5
) (
    input  logic             clk,
    input  logic             reset,
    ex_mem_pipe_reg_if.slave bus
);

    typedef struct packed {
        logic [CTRL_M_W-1:0]  mem;
        logic [CTRL_WB_W-1:0] wb;
        logic [DATA_W-1:0]    alu;
        logic [DATA_W-1:0]    wdata;
        logic [REG_W-1:0]     wreg;
    } entry_t;

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   main_vld_q, main_vld_d;
    logic   skid_vld_q, skid_vld_d;
    entry_t in_ent;
    logic   pop;
    logic   push;
    logic   rdy_e;

    assign in_ent.mem   = bus.MEM_E;
    assign in_ent.wb    = bus.WB_E;
    assign in_ent.alu   = bus.ALUOut_E;
    assign in_ent.wdata = bus.WriteData_E;
    assign in_ent.wreg  = bus.WriteReg_E;

    assign rdy_e = !skid_vld_q;
    assign pop   = main_vld_q && bus.ready_m;
    assign push  = bus.valid_e && rdy_e;

    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        if (bus.flush) begin
            // Data survives a flush; only control is scrubbed.
            main_vld_d  = 1'b0;
            skid_vld_d  = 1'b0;
            main_d.mem  = '0;
            main_d.wb   = '0;
            skid_d.mem  = '0;
            skid_d.wb   = '0;
        end else if (!main_vld_q) begin
            if (push) begin
                main_d     = in_ent;
                main_vld_d = 1'b1;
            end
        end else if (pop) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end else if (push) begin
                main_d = in_ent;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (push) begin
            skid_d     = in_ent;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign bus.ready_e     = rdy_e;
    assign bus.valid_m     = main_vld_q;
    assign bus.MEM_M       = main_vld_q ? main_q.mem : '0;
    assign bus.WB_M        = main_vld_q ? main_q.wb  : '0;
    assign bus.ALUOut_M    = main_q.alu;
    assign bus.WriteData_M = main_q.wdata;
    assign bus.WriteReg_M  = main_q.wreg;
    assign bus.occupancy   = {1'b0, main_vld_q} + {1'b0, skid_vld_q};

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Bench for ex_mem_pipe_reg: queue reference model, directed and random
// stimulus, plus a 64-bit/6-bit-register instance.
module tb_ex_mem_pipe_reg;

    typedef struct packed {
        logic [1:0]  mem;
        logic [1:0]  wb;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  wr;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;
    ent_t q[$];
    ent_t held;

    always #5 clk = ~clk;

    ex_mem_pipe_reg_if d ();
    ex_mem_pipe_reg_if #(.DATA_W(64), .REG_W(6)) w ();

    ex_mem_pipe_reg dut (
        .clk   (clk),
        .reset (rst),
        .bus   (d.slave)
    );

    ex_mem_pipe_reg #(.DATA_W(64), .REG_W(6)) dut_w (
        .clk   (clk),
        .reset (rst),
        .bus   (w.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input ent_t e);
        d.valid_e     = v;
        d.MEM_E       = e.mem;
        d.WB_E        = e.wb;
        d.ALUOut_E    = e.alu;
        d.WriteData_E = e.wd;
        d.WriteReg_E  = e.wr;
    endtask

    function automatic ent_t mk(input logic [31:0] alu, input logic [4:0] wr);
        ent_t e;
        e.mem = alu[1:0];
        e.wb  = alu[3:2] | 2'b01;
        e.alu = alu;
        e.wd  = ~alu;
        e.wr  = wr;
        return e;
    endfunction

    function automatic ent_t rnd();
        ent_t e;
        e.mem = 2'($urandom);
        e.wb  = 2'($urandom);
        e.alu = $urandom;
        e.wd  = $urandom;
        e.wr  = 5'($urandom);
        return e;
    endfunction

    // Check head outputs against the model, advance the model, clock once.
    task automatic step();
        ent_t hd;
        ent_t in;
        bit   ne;
        bit   acc;
        ne = (q.size() != 0);
        hd = ne ? q[0] : held;
        chk("valid_m", 64'(d.valid_m), 64'(ne));
        chk("ready_e", 64'(d.ready_e), 64'(q.size() < 2));
        chk("occupancy", 64'(d.occupancy), 64'(q.size()));
        chk("MEM_M", 64'(d.MEM_M), ne ? 64'(hd.mem) : 64'd0);
        chk("WB_M", 64'(d.WB_M), ne ? 64'(hd.wb) : 64'd0);
        chk("ALUOut_M", 64'(d.ALUOut_M), 64'(hd.alu));
        chk("WriteData_M", 64'(d.WriteData_M), 64'(hd.wd));
        chk("WriteReg_M", 64'(d.WriteReg_M), 64'(hd.wr));
        in = '{d.MEM_E, d.WB_E, d.ALUOut_E, d.WriteData_E, d.WriteReg_E};
        if (rst) begin
            q.delete();
            held = '0;
        end else if (d.flush) begin
            q.delete();
        end else begin
            acc = d.valid_e && (q.size() < 2);
            if (q.size() != 0 && d.ready_m) void'(q.pop_front());
            if (acc) q.push_back(in);
        end
        if (q.size() != 0) held = q[0];
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, '0);
        d.flush = 1'b0;
        d.ready_m = 1'b0;
        w.valid_e = 1'b0;
        w.flush = 1'b0;
        w.ready_m = 1'b0;
        w.MEM_E = '0;
        w.WB_E = '0;
        w.ALUOut_E = '0;
        w.WriteData_E = '0;
        w.WriteReg_E = '0;
        @(posedge clk);
        #1;
        q.delete();
        held = '0;
        rst = 1'b0;
        step();

        // streaming at full rate
        d.ready_m = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, mk(32'(i), 5'(i)));
            step();
        end
        drive(1'b0, '0);
        step();
        step();

        // stall: A, B, C with MEM stalled, then drain
        d.ready_m = 1'b0;
        drive(1'b1, mk(32'h10, 5'd1));
        step();
        drive(1'b1, mk(32'h20, 5'd2));
        step();
        drive(1'b1, mk(32'h30, 5'd3));
        step();
        step();
        d.ready_m = 1'b1;
        step();
        drive(1'b0, '0);
        for (int i = 0; i < 3; i++) step();

        // flush while full with a same-edge push
        d.ready_m = 1'b0;
        drive(1'b1, mk(32'h40, 5'd4));
        step();
        drive(1'b1, mk(32'h50, 5'd5));
        step();
        drive(1'b1, mk(32'h60, 5'd6));
        d.WB_E = 2'b01;
        d.flush = 1'b1;
        step();
        d.flush = 1'b0;
        drive(1'b0, '0);
        d.ready_m = 1'b1;
        step();
        step();

        // bubble gating keeps last WriteReg
        drive(1'b1, mk(32'h77, 5'd7));
        step();
        drive(1'b0, '0);
        for (int i = 0; i < 3; i++) step();
        chk("bubble_wreg", 64'(d.WriteReg_M), 64'd7);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), rnd());
            d.ready_m = 1'($urandom_range(0, 2) != 0);
            d.flush = ($urandom_range(0, 24) == 0);
            step();
        end
        d.flush = 1'b0;

        // reset mid-stream at occupancy 2
        d.ready_m = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, rnd());
            step();
        end
        drive(1'b0, '0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        step();

        // wide instance passes 64-bit data intact
        w.valid_e = 1'b1;
        w.MEM_E = 2'b10;
        w.WB_E = 2'b11;
        w.ALUOut_E = 64'hDEADBEEF_CAFEF00D;
        w.WriteData_E = 64'h0123_4567_89AB_CDEF;
        w.WriteReg_E = 6'd40;
        @(posedge clk);
        #1;
        w.valid_e = 1'b0;
        chk("w_valid", 64'(w.valid_m), 64'd1);
        chk("w_alu", w.ALUOut_M, 64'hDEADBEEF_CAFEF00D);
        chk("w_wd", w.WriteData_M, 64'h0123_4567_89AB_CDEF);
        chk("w_wreg", 64'(w.WriteReg_M), 64'd40);
        chk("w_mem", 64'(w.MEM_M), 64'd2);
        chk("w_wb", 64'(w.WB_M), 64'd3);
        w.ready_m = 1'b1;
        @(posedge clk);
        #1;
        chk("w_valid_off", 64'(w.valid_m), 64'd0);
        chk("w_wb_off", 64'(w.WB_M), 64'd0);
        chk("w_alu_hold", w.ALUOut_M, 64'hDEADBEEF_CAFEF00D);
        chk("w_wreg_hold", 64'(w.WriteReg_M), 64'd40);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ex_mem_pipe_reg.md
Name: ex_mem_pipe_reg

Overview:
Parametrised EX→MEM pipeline register, the successor to the fixed-width EX/MEM latch. It adds a valid/ready handshake, a 2-entry skid buffer so the MEM stage can stall (multi-cycle data memory) without a combinational ready path back into EX, synchronous flush, and bubble zeroing of the control fields. It sits between the EX stage/ALU and the MEM stage/data memory, and also feeds the hazard/forwarding unit.

Parameters:
CTRL_M_W, 2, width of MEM-stage control field (MemWrite, MemRead)
CTRL_WB_W, 2, width of WB-stage control field (bit0 = RegWrite, bit1 = MemtoReg)
DATA_W, 32, width of ALUOut and WriteData
REG_W, 5, width of destination register index

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
valid_e  in  1  EX presents a valid instruction
ready_e  out  1  register can accept; transfer when valid_e && ready_e
flush  in  1  kill all held entries (branch/exception)
MEM_E  in  CTRL_M_W  MEM control from EX
WB_E  in  CTRL_WB_W  WB control from EX
ALUOut_E  in  DATA_W  ALU result
WriteData_E  in  DATA_W  store data
WriteReg_E  in  REG_W  destination register
valid_m  out  1  head entry valid toward MEM
ready_m  in  1  MEM consumes head; transfer when valid_m && ready_m
MEM_M  out  CTRL_M_W  head MEM control, forced 0 when !valid_m
WB_M  out  CTRL_WB_W  head WB control, forced 0 when !valid_m
ALUOut_M  out  DATA_W  head ALU result (held value when invalid)
WriteData_M  out  DATA_W  head store data
WriteReg_M  out  REG_W  head destination register
occupancy  out  2  entries held (0..2), for the hazard unit

Behaviour:
- Storage: main entry (drives *_M outputs) + skid entry, each with a valid bit. All state is registered; no combinational path from ready_m to ready_e.
- ready_e = !skid_valid (registered state). occupancy = main_valid + skid_valid.
- Reset (synchronous, highest priority): main_valid = skid_valid = 0; all payload regs = 0; so valid_m=0, every *_M output = 0, ready_e=1, occupancy=0.
- flush (next priority): clears both valid bits and zeroes MEM/WB control in both entries at the edge; valid_e on the same edge is discarded (not captured). Data fields need not be cleared. Next cycle: valid_m=0, ready_e=1.
- Normal edge; let pop = valid_m && ready_m, push = valid_e && ready_e:
  - main empty, push: input → main. Latency: 1 cycle from EX accept to valid_m.
  - main full, pop, skid empty, push: input → main.
  - main full, pop, skid full: skid → main, skid cleared (push impossible, ready_e=0).
  - main full, !pop, push (skid empty): input → skid; ready_e drops next cycle.
  - main full, pop, no push, skid empty: main cleared.
  - neither: hold.
- Order is strictly FIFO; no entry is lost or duplicated under any ready_m pattern.
- Bubble rule: MEM_M and WB_M read 0 whenever valid_m=0, so MEM never writes memory or the register file on a bubble.
- Full-throughput: with ready_m held 1, one instruction per cycle, occupancy ≤1.
- Widths are fixed by the parameters; no arithmetic is performed.

Test Plan:
- Reset mid-stream: occupancy=2, assert reset one cycle → next cycle valid_m=0, MEM_M=WB_M=0, ALUOut_M=0, ready_e=1, occupancy=0.
- Streaming: ready_m=1, push ALUOut_E=1,2,3,4 on consecutive cycles → ALUOut_M=1,2,3,4 one cycle later each, valid_m continuous, ready_e never 0.
- Stall/skid: push A (0x10), B (0x20), C with ready_m=0 → A in main, B in skid, ready_e=0 and C held by EX; raise ready_m → outputs A, B, C in order, occupancy sequence 2,1,1,0 with no loss.
- Flush with push: occupancy=2 and valid_e=1 with WB_E=2'b01 on the same edge as flush → next cycle valid_m=0, WB_M=0, occupancy=0; the pushed instruction never appears.
- Bubble gating: hold valid_e=0 after draining → WB_M=0, MEM_M=0 while WriteReg_M keeps its last value (e.g. 5'd7).
- Parameter sweep: DATA_W=64, REG_W=6 → 64-bit ALUOut 0xDEADBEEF_CAFEF00D and WriteReg 6'd40 pass through intact.
